// File: rtl/ising_spin_update.sv
// Serial Ising spin update: adds shifted LFSR noise to each local field and
// thresholds it to a +/-1 spin, publishing the whole vector once per sweep.
module ising_spin_update #(
  parameter int unsigned           NUM_SPINS  = 4,
  parameter int unsigned           DATABITS   = 32,
  parameter int unsigned           NOISE_BITS = 16,
  parameter logic [NOISE_BITS-1:0] LFSR_SEED  = NOISE_BITS'(16'hACE1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATABITS*NUM_SPINS-1:0] fields_i,
  input  logic                          fields_valid_i,
  input  logic                          noise_en_i,
  input  logic [4:0]                    noise_shift_i,
  output logic [NUM_SPINS-1:0]          spins_o,
  output logic [DATABITS*NUM_SPINS-1:0] spin_vector_o,
  output logic                          spins_valid_o,
  output logic                          busy_o,
  output logic [31:0]                   iteration_count_o
);

  localparam int unsigned NW   = DATABITS + 1;
  localparam int unsigned SW   = DATABITS + 2;
  localparam int unsigned IDXW = (NUM_SPINS > 1) ? $clog2(NUM_SPINS) : 1;

  localparam logic [NOISE_BITS-1:0] LFSR_MASK = NOISE_BITS'(16'hB400);
  localparam logic [NOISE_BITS-1:0] LFSR_INIT =
    (LFSR_SEED == '0) ? NOISE_BITS'(1) : LFSR_SEED;
  localparam logic [IDXW-1:0]     LAST_IDX = IDXW'(NUM_SPINS - 1);
  localparam logic [DATABITS-1:0] LANE_POS = DATABITS'(1);
  localparam logic [DATABITS-1:0] LANE_NEG = '1;

  typedef enum logic {S_IDLE, S_UPDATE} state_e;

  state_e                              state_q;
  logic [NUM_SPINS-1:0][DATABITS-1:0]  field_buf_q;
  logic [IDXW-1:0]                     idx_q;
  logic [NOISE_BITS-1:0]               lfsr_q;
  logic [NOISE_BITS-1:0]               lfsr_d;
  logic [NUM_SPINS-1:0]                work_spins_q;
  logic [NUM_SPINS-1:0]                work_spins_d;
  logic [NUM_SPINS-1:0]                spins_q;
  logic [DATABITS*NUM_SPINS-1:0]       spin_vector_q;
  logic [DATABITS*NUM_SPINS-1:0]       spin_vector_d;
  logic                                spins_valid_q;
  logic                                busy_q;
  logic [31:0]                         iter_q;

  logic [DATABITS-1:0] field_cur;
  logic signed [NW-1:0] noise_ext;
  logic signed [NW-1:0] noise;
  logic signed [SW-1:0] sum;
  logic                 new_spin;

  // Noise/threshold datapath for the spin currently addressed by idx_q.
  // Sum is two bits wider than a lane so saturated fields plus noise never wrap.
  always_comb begin
    field_cur = field_buf_q[idx_q];
    noise_ext = {{(NW-NOISE_BITS){lfsr_q[NOISE_BITS-1]}}, lfsr_q};
    noise     = noise_en_i ? (noise_ext <<< noise_shift_i) : '0;
    sum       = {{2{field_cur[DATABITS-1]}}, field_cur} + {noise[NW-1], noise};
    new_spin  = (sum >= 0);

    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_MASK;
    end

    work_spins_d        = work_spins_q;
    work_spins_d[idx_q] = new_spin;

    spin_vector_d = '0;
    for (int i = 0; i < int'(NUM_SPINS); i++) begin
      spin_vector_d[i*DATABITS +: DATABITS] = work_spins_d[i] ? LANE_POS : LANE_NEG;
    end
  end

  // Sweep FSM; published outputs only move on the final spin of a sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      field_buf_q   <= '0;
      idx_q         <= '0;
      lfsr_q        <= LFSR_INIT;
      work_spins_q  <= '1;
      spins_q       <= '1;
      spin_vector_q <= {NUM_SPINS{LANE_POS}};
      spins_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      iter_q        <= '0;
    end else begin
      spins_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fields_valid_i) begin
            field_buf_q <= fields_i;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          work_spins_q <= work_spins_d;
          if (noise_en_i) begin
            lfsr_q <= lfsr_d;
          end
          if (idx_q == LAST_IDX) begin
            spins_q       <= work_spins_d;
            spin_vector_q <= spin_vector_d;
            spins_valid_q <= 1'b1;
            iter_q        <= iter_q + 32'd1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spins_o           = spins_q;
  assign spin_vector_o     = spin_vector_q;
  assign spins_valid_o     = spins_valid_q;
  assign busy_o            = busy_q;
  assign iteration_count_o = iter_q;

endmodule

// File: doc/ising_spin_update.md
# ising_spin_update

Downstream stage of the matrix-multiply block in the recurrent Ising sampler. Takes the local-field vector (coupling matrix × spin vector) produced by the multiplier, adds LFSR-generated noise, and thresholds each field to a new ±1 spin. It emits the updated spin vector in the multiplier's 32-bit lane format, ready to feed back as the next iteration's input. Spins are processed serially, one per cycle, under a small FSM with a valid/busy handshake.

## Interface
- NUM_SPINS, 4, number of spins/field lanes (≥1)
- DATABITS, 32, width of each signed field lane and output lane
- NOISE_BITS, 16, LFSR width; fixed Galois polynomial mask 16'hB400 at 16
- LFSR_SEED, 16'hACE1, LFSR reset value; a seed of 0 is replaced by 1
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- fields  in  DATABITS*NUM_SPINS  signed local fields, lane i at [i*DATABITS +: DATABITS]
- fields_valid  in  1  fields stable; sampled only when busy=0
- noise_en  in  1  1: add noise; 0: noise term forced to 0
- noise_shift  in  5  left arithmetic shift applied to noise sample
- spins  out  NUM_SPINS  bit i=1 means spin i = +1, 0 means −1
- spin_vector  out  DATABITS*NUM_SPINS  lane i = +1 (32'h00000001) or −1 (all ones), same layout as fields
- spins_valid  out  1  one-cycle pulse when spins/spin_vector update
- busy  out  1  high from capture through last spin update
- iteration_count  out  32  completed update sweeps, wraps at 2^32

## Operation
- FSM states: IDLE, UPDATE. IDLE: on fields_valid=1, capture all lanes into field_buf, set idx=0, busy=1, go to UPDATE. fields_valid=0 stays in IDLE.
- UPDATE, each cycle for spin idx:
  - noise = sign-extend(lfsr) <<< noise_shift, computed at DATABITS+1 bits with the shift result truncated to DATABITS+1. Noise is 0 if noise_en=0.
  - sum = sext(field_buf[idx]) + noise at DATABITS+2 bits. No wrap is allowed.
  - new spin = +1 if sum ≥ 0, else −1. Write it to work_spins[idx].
  - The LFSR advances one step only when noise_en=1. Step: lsb=lfsr[0]; lfsr=lfsr>>1; if lsb, lfsr^=16'hB400.
  - If idx=NUM_SPINS−1: copy work_spins (including this update) to spins/spin_vector, pulse spins_valid, increment iteration_count, clear busy, go to IDLE. Otherwise idx+1.
- Outputs change only on the spins_valid edge. The multiplier never sees a partially updated vector.
- fields_valid while busy=1 is ignored and not queued.
- noise_en and noise_shift are sampled per spin cycle. Changing them mid-sweep affects the remaining spins.

## Timing
- Reset values: spins = all 1, every spin_vector lane = 32'h00000001, spins_valid=0, busy=0, iteration_count=0, lfsr=LFSR_SEED, state IDLE, work_spins all +1.
- Capture at edge E. Spin i is updated at edge E+1+i. spins/spin_vector/spins_valid/iteration_count update at edge E+NUM_SPINS. busy=0 from that edge.
- spins_valid is high exactly one cycle. Latency from fields_valid to spins_valid is NUM_SPINS+1 cycles. The earliest next capture is at edge E+NUM_SPINS+1 (back-to-back sweeps with a 1-cycle gap).
- rst overrides everything, including mid-sweep. The sweep is abandoned, no spins_valid is produced, and all outputs and the LFSR return to reset values on that edge.
- rst and fields_valid in the same cycle: reset wins and nothing is captured.

## Test plan
- Reset: hold rst 2 cycles → spins=4'b1111, all lanes 32'h00000001, busy=0, spins_valid=0, iteration_count=0.
- Deterministic threshold: noise_en=0, fields lanes {−5, 0, 7, −1} (lane0..3), fields_valid at edge E → busy=1 during E..E+3, spins_valid single pulse after edge E+4, spins=4'b0110, lanes {32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF}, iteration_count=1.
- LFSR sequence: after reset, noise_en=1, noise_shift=0, all fields 0. Noise samples are 0xACE1, 0xE270, 0x7138, 0x389C. Expect spins=4'b1100 and final internal lfsr=0x1C4E.
- Overflow: noise_en=1, noise_shift=31. Lane0=32'h7FFFFFFF with positive noise → +1. Lane1=32'h80000000 with negative noise → −1. No wrap-around sign flips, checked against a wide-integer reference model.
- Busy handling: pulse fields_valid at E and again at E+2 with different data → exactly one spins_valid, result from first data, iteration_count=1. A third pulse at E+5 is accepted.
- Reset mid-sweep: rst at edge E+2 → no spins_valid ever, outputs at reset values, lfsr back to 0xACE1. A following sweep reproduces the LFSR test result.
